interrupt_controller: RTL
=========================

# interrupt_controller

Parametrised, nesting interrupt controller for the core; it replaces the fixed two-input interrupt state machine. It samples NUM_IRQ level-sensitive requests and arbitrates them by fixed priority against a per-line mask and a global enable. It decides at instruction boundaries, in step with the master sequencer phases, and drives the program-counter vector load plus condition-code save/restore. A hardware nesting stack of depth NEST_DEPTH lets higher-priority requests preempt lower-priority handlers.

## Interface
- NUM_IRQ, 4: number of request lines, 1..8; index 0 is highest priority.
- NEST_DEPTH, 2: maximum simultaneously active handlers, 1..4.
- VECTOR_BASE, 16'h0010: address of the vector for line 0.
- VECTOR_SHIFT, 2: vector stride is 2^VECTOR_SHIFT words.
- CLK  in  1  single core clock; all state is updated on the rising edge.
- RESET  in  1  asynchronous, active-high.
- EXECUTE  in  1  execute-phase strobe from the master sequencer.
- COMMIT  in  1  commit-phase strobe from the master sequencer.
- EIX, DIX, RETIX  in  1 each  decoded EI, DI and RETI; qualified by COMMIT.
- INT  in  NUM_IRQ  asynchronous level requests.
- MASK_WR  in  1  loads MASK_DIN into MASK.
- MASK_DIN  in  NUM_IRQ  new mask; 1 = line enabled.
- MASK  out  NUM_IRQ  current mask.
- IE  out  1  global interrupt enable.
- PC_LD_INTX  out  1  program counter loads INT_VECTOR.
- INT_VECTOR  out  16  vector of the line being taken.
- CCL_SAVEX  out  1  push the condition codes.
- CCL_RESTX  out  1  pop the condition codes.
- INT_ACK  out  NUM_IRQ  one-hot acknowledge pulse.
- INT_LEVEL  out  3  current nesting depth, 0..NEST_DEPTH.
- RETI_ERR  out  1  sticky: RETI was executed at level 0.

## Operation
- **Synchroniser:** each INT bit passes through a 2-flop synchroniser, giving SINT.
- **Qualified requests:** QREQ = SINT & MASK.
- **Winner:** the lowest set index of QREQ.
- **Stack:** holds NEST_DEPTH entries, each a line index plus a valid bit. CUR is the index on top of the stack, or "none" at level 0.
- **Eligibility:** a take is eligible when all of the following hold:
  - IE = 1;
  - INT_LEVEL < NEST_DEPTH;
  - a winner exists;
  - at level 0, or the winner index is less than CUR.
- **State machine:**
  - IDLE -> ARMED on EXECUTE when a take is eligible and the current instruction is not DIX or RETIX. ARMED latches the winner index W.
  - In ARMED, during the COMMIT cycle:
    - PC_LD_INTX = 1 and CCL_SAVEX = 1;
    - INT_VECTOR = VECTOR_BASE + (W << VECTOR_SHIFT), modulo 2^16;
    - INT_ACK[W] = 1.
  - At the end of that COMMIT: push W, INT_LEVEL++, IE <- 0, return to IDLE.
- **Late drop:** if INT[W] drops after arming, the take still completes. The line is level-sensitive, so the device keeps its request until INT_ACK and then deasserts it.
- **EIX at COMMIT:** IE <- 1. It takes effect from the next EXECUTE, so at least one further instruction runs before a take.
- **DIX at COMMIT:** IE <- 0.
- **RETIX at COMMIT, level > 0:**
  - CCL_RESTX = 1 for that cycle;
  - pop the stack, INT_LEVEL--;
  - IE <- 1.
- **RETIX at COMMIT, level 0:** no pop and no CCL_RESTX; RETI_ERR <- 1.
- **MASK_WR:** takes effect on the next edge. It never cancels an ARMED take.
- **Simultaneous events:**
  - RETIX and an eligible request in the same instruction: RETI completes and no take is armed. The request is re-evaluated at the next EXECUTE.
  - EIX and DIX together: not produced by the decoder; DIX wins.
  - MASK_WR in the same cycle as EXECUTE: arbitration uses the old MASK.

## Timing
- **Reset values:**
  - state IDLE, stack empty, INT_LEVEL = 0, IE = 0;
  - MASK = all ones, synchronisers 0, RETI_ERR = 0;
  - PC_LD_INTX, CCL_SAVEX, CCL_RESTX = 0, INT_ACK = 0;
  - INT_VECTOR = VECTOR_BASE.
- **RESET asserted mid-operation,** including while ARMED: all state clears immediately; no pulse is emitted.
- **Latency:**
  - INT rising at edge t appears in SINT after edge t+2.
  - SINT must be high at an EXECUTE cycle to arm.
  - PC_LD_INTX is then asserted in the following cycle (COMMIT).
- **Worst case from INT to PC_LD_INTX:** 2 synchroniser cycles plus one full instruction (4 phases) plus 1 cycle.
- **Pulse width:** PC_LD_INTX, CCL_SAVEX, CCL_RESTX and INT_ACK are each exactly one cycle wide, coincident with COMMIT.
- **INT_VECTOR:** holds its value outside takes.
- **Output registration:** all outputs come from registers, except the COMMIT-qualified pulses, which are ANDed with COMMIT.

## Test plan
- **Reset and EI:** reset, EI, then INT = 4'b0100. Required: INT_VECTOR = 16'h0018; PC_LD_INTX, CCL_SAVEX and INT_ACK = 4'b0100 in one COMMIT; IE = 0; INT_LEVEL = 1.
- **Priority:** INT = 4'b1010 asserted together with IE = 1. Required: line 1 taken, vector 16'h0014. Then EI inside the handler: line 3 is not taken, because index 3 is not less than 1.
- **Nesting limit:** active line 3, EI, then assert line 0 (NEST_DEPTH = 2). Required: preempted, INT_LEVEL = 2. Assert line 0 again after EI: no take, because the stack is full. Two RETIs: CCL_RESTX twice, INT_LEVEL returns to 0.
- **Mask and DI:** MASK_DIN = 4'b1110 with INT[0] high: no take. DI in the same instruction as an eligible request: no take, IE = 0.
- **RETI boundary:** RETI at level 0: RETI_ERR = 1, no CCL_RESTX, INT_LEVEL stays 0. Next, RETIX and a pending request in the same instruction: the take happens one instruction later.
- **Reset while ARMED:** assert RESET between EXECUTE and COMMIT. Required: no PC_LD_INTX, all outputs at reset values, MASK = 4'b1111.

Source files
------------

// File: rtl/interrupt_controller.sv
// interrupt_controller: nesting fixed-priority interrupt controller with vector load and CC save/restore
module interrupt_controller #(
  parameter int          NUM_IRQ      = 4,
  parameter int          NEST_DEPTH   = 2,
  parameter logic [15:0] VECTOR_BASE  = 16'h0010,
  parameter int          VECTOR_SHIFT = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               execute_i,
  input  logic               commit_i,
  input  logic               eix_i,
  input  logic               dix_i,
  input  logic               retix_i,
  input  logic [NUM_IRQ-1:0] int_i,
  input  logic               mask_wr_i,
  input  logic [NUM_IRQ-1:0] mask_din_i,
  output logic [NUM_IRQ-1:0] mask_o,
  output logic               ie_o,
  output logic               pc_ld_intx_o,
  output logic [15:0]        int_vector_o,
  output logic               ccl_savex_o,
  output logic               ccl_restx_o,
  output logic [NUM_IRQ-1:0] int_ack_o,
  output logic [2:0]         int_level_o,
  output logic               reti_err_o
);
  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  typedef enum logic {IDLE, ARMED} state_e;
  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] sync1_q, sint_q, mask_q, qreq;
  logic [IW-1:0]      stack_q [NEST_DEPTH];
  logic [NEST_DEPTH-1:0] valid_q;
  logic [IW-1:0]      win, cur, w_q;
  logic               found, cur_v, elig, take, done, reti_ok, reti_bad;
  logic [2:0]         level_q;
  logic               ie_q, err_q;
  logic [15:0]        vec_q;
  // Fixed-priority winner among unmasked synchronised requests and preemption check against the active handler
  always_comb begin
    qreq  = sint_q & mask_q;
    found = 1'b0;
    win   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (qreq[i]) begin
        found = 1'b1;
        win   = IW'(i);
      end
    cur   = '0;
    cur_v = 1'b0;
    for (int i = 0; i < NEST_DEPTH; i++)
      if (level_q == 3'(i + 1)) begin
        cur   = stack_q[i];
        cur_v = valid_q[i];
      end
    elig = ie_q && (level_q < 3'(NEST_DEPTH)) && found && (!cur_v || win < cur);
  end
  assign take = execute_i && elig && !dix_i && !retix_i;
  // Next state: arm at an eligible EXECUTE, complete the take at the following COMMIT
  always_comb begin
    state_d = (state_q == IDLE) ? (take ? ARMED : IDLE) : (commit_i ? IDLE : ARMED);
  end
  // COMMIT-qualified pulses; everything else comes straight from registers
  always_comb begin
    done         = (state_q == ARMED) && commit_i;
    reti_ok      = commit_i && retix_i && (level_q != 3'd0);
    reti_bad     = commit_i && retix_i && (level_q == 3'd0);
    pc_ld_intx_o = done;
    ccl_savex_o  = done;
    ccl_restx_o  = reti_ok;
    int_ack_o    = done ? (NUM_IRQ'(1) << w_q) : '0;
  end
  assign mask_o       = mask_q;
  assign ie_o         = ie_q;
  assign int_vector_o = vec_q;
  assign int_level_o  = level_q;
  assign reti_err_o   = err_q;
  // State register; winner and its vector are latched on arming so they are stable through COMMIT
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      w_q     <= '0;
      vec_q   <= VECTOR_BASE;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && take) begin
        w_q   <= win;
        vec_q <= VECTOR_BASE + (16'(win) << VECTOR_SHIFT);
      end
    end
  end
  // Two-flop synchroniser on the asynchronous request lines
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= '0;
      sint_q  <= '0;
    end else begin
      sync1_q <= int_i;
      sint_q  <= sync1_q;
    end
  end
  // Mask, global enable, nesting stack and sticky RETI error
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mask_q  <= '1;
      ie_q    <= 1'b0;
      level_q <= '0;
      err_q   <= 1'b0;
      valid_q <= '0;
      for (int i = 0; i < NEST_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      if (mask_wr_i) mask_q <= mask_din_i;
      ie_q    <= done ? 1'b0 : (commit_i && dix_i) ? 1'b0 : ((commit_i && eix_i) || reti_ok) ? 1'b1 : ie_q;
      level_q <= done ? level_q + 3'd1 : reti_ok ? level_q - 3'd1 : level_q;
      err_q   <= err_q | reti_bad;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        if (done && level_q == 3'(i)) begin
          stack_q[i] <= w_q;
          valid_q[i] <= 1'b1;
        end
        if (reti_ok && level_q == 3'(i + 1)) valid_q[i] <= 1'b0;
      end
    end
  end
endmodule
